hub75_rx: RTL

- Panel-side receiver for the HUB75 LED-matrix interface: A–D, R0/G0/B0, R1/G1/B1, shift clock, LAT, OE.
- Oversamples the HUB75 pins on the system clock, shifts in one row pair, and copies it to a shadow latch on LAT.
- Drains the latched line as a pixel write stream into a frame buffer or scoreboard.
- Used as an on-FPGA loopback monitor for the matrix driver and as the capture model in simulation.

---
 rtl/hub75_pkg.sv | 15 +
 rtl/hub75_sync.sv | 39 +++
 rtl/hub75_rx.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// Shared constants and types for the HUB75 panel-side receiver.
package hub75_pkg;

    localparam int COLS_DEF    = 32;
    localparam int ADDR_W_DEF  = 4;
    localparam int SYNC_STAGES = 2;

    typedef logic [2:0] rgb_t;

    typedef enum logic {
        IDLE,
        DRAIN
    } rx_state_t;

endpackage

// File: rtl/hub75_sync.sv
// Multi-flop synchroniser for async pins plus rising-edge detect on the control bits.
// Data and control leave the same flop stage, so a captured edge and its data stay aligned.
module hub75_sync
    import hub75_pkg::*;
#(
    parameter int              DW      = 1,
    parameter int              EW      = 1,
    parameter logic [DW-1:0]   DAT_RST = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [EW-1:0] ctl_in,
    input  logic [DW-1:0] dat_in,
    output logic [DW-1:0] dat_out,
    output logic [EW-1:0] rise
);

    logic [EW+DW-1:0] stg [SYNC_STAGES];
    logic [EW-1:0]    ctl_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stg[i] <= {DAT_RST, {EW{1'b0}}};
            end
            ctl_q <= '0;
        end else begin
            stg[0] <= {dat_in, ctl_in};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stg[i] <= stg[i-1];
            end
            ctl_q <= stg[SYNC_STAGES-1][EW-1:0];
        end
    end

    assign dat_out = stg[SYNC_STAGES-1][EW +: DW];
    assign rise    = stg[SYNC_STAGES-1][EW-1:0] & ~ctl_q;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 receiver: shifts a row pair, latches it on LAT, drains it as a 1 pixel/cycle valid/ready stream.
// Pin edge acted on 3 clk later; wr outputs hold until wr_ready. HUB75_RX_STATS_EN adds line/drop counters.
module hub75_rx
    import hub75_pkg::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hub_clk,
    input  logic                    hub_lat,
    input  logic                    hub_oe,
    input  logic [ADDR_W-1:0]       hub_addr,
    input  logic [2:0]              hub_rgb0,
    input  logic [2:0]              hub_rgb1,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [ADDR_W:0]         wr_row,
    output logic [$clog2(COLS)-1:0] wr_col,
    output logic [2:0]              wr_rgb,
    output logic                    frame_done,
    output logic                    len_err,
    output logic                    ovr_err,
    output logic                    panel_on
`ifdef HUB75_RX_STATS_EN
    ,
    output logic [15:0]             line_cnt,
    output logic [15:0]             drop_cnt
`endif
);

    localparam int CW    = $clog2(COLS);
    localparam int CNT_W = CW + 1;
    localparam int PW    = CW + 1;
    localparam int SW    = 1 + 3 + 3 + ADDR_W;
    localparam int LW    = 3 * COLS;

    localparam logic [SW-1:0]    SYNC_RST = {1'b1, {(SW-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(COLS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(COLS + 1);

    logic              clk_rise;
    logic              lat_rise;
    logic              s_oe;
    rgb_t              s_rgb0;
    rgb_t              s_rgb1;
    logic [ADDR_W-1:0] s_addr;

    hub75_sync #(
        .DW      (SW),
        .EW      (2),
        .DAT_RST (SYNC_RST)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .ctl_in  ({hub_lat, hub_clk}),
        .dat_in  ({hub_oe, hub_rgb1, hub_rgb0, hub_addr}),
        .dat_out ({s_oe, s_rgb1, s_rgb0, s_addr}),
        .rise    ({lat_rise, clk_rise})
    );

    assign panel_on = ~s_oe;

    logic [LW-1:0]     sh0, sh1, lat0, lat1;
    logic [ADDR_W-1:0] lat_addr;
    logic [CNT_W-1:0]  cnt;
    logic [PW-1:0]     pix;
    rx_state_t         state;

    logic              line_ok;
    logic              commit;
    logic              last_pix;
    logic [CW-1:0]     pcol;

    assign line_ok  = (cnt == CNT_FULL);
    assign commit   = lat_rise && line_ok && (state == IDLE);
    assign last_pix = wr_row[ADDR_W] && (wr_col == CW'(COLS - 1));
    assign pcol     = pix[CW-1:0];

    // Newest bit enters at the bottom, so column c ends up at bits [3c+2:3c].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh0 <= '0;
            sh1 <= '0;
            cnt <= '0;
        end else begin
            if (clk_rise) begin
                sh0 <= {sh0[LW-4:0], s_rgb0};
                sh1 <= {sh1[LW-4:0], s_rgb1};
            end
            if (lat_rise) begin
                cnt <= clk_rise ? CNT_W'(1) : '0;
            end else if (clk_rise && cnt != CNT_SAT) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            lat0       <= '0;
            lat1       <= '0;
            lat_addr   <= '0;
            pix        <= '0;
            wr_valid   <= 1'b0;
            wr_row     <= '0;
            wr_col     <= '0;
            wr_rgb     <= '0;
            frame_done <= 1'b0;
            len_err    <= 1'b0;
            ovr_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (lat_rise) begin
                if (!line_ok) begin
                    len_err <= 1'b1;
                end else if (state == DRAIN) begin
                    ovr_err <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (commit) begin
                        lat0     <= sh0;
                        lat1     <= sh1;
                        lat_addr <= s_addr;
                        pix      <= '0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!wr_valid || wr_ready) begin
                        if (wr_valid && last_pix) begin
                            wr_valid   <= 1'b0;
                            frame_done <= &lat_addr;
                            state      <= IDLE;
                        end else begin
                            wr_valid <= 1'b1;
                            wr_row   <= {pix[CW], lat_addr};
                            wr_col   <= pcol;
                            wr_rgb   <= pix[CW] ? lat1[3*int'(pcol) +: 3]
                                                : lat0[3*int'(pcol) +: 3];
                            pix      <= pix + PW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HUB75_RX_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (commit) begin
                line_cnt <= line_cnt + 16'd1;
            end
            if (lat_rise && !commit) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
